// File: rtl/rtc_pkg.sv
// Shared limits, types and helpers for the BCD real-time clock core.
// Used by rtc_timekeeper and rtc_prescaler.
package rtc_pkg;

  localparam logic [3:0] SECL_MAX = 4'd9;
  localparam logic [3:0] SECM_MAX = 4'd5;
  localparam logic [3:0] MINL_MAX = 4'd9;
  localparam logic [3:0] MINM_MAX = 4'd5;
  localparam logic [3:0] HRL_MAX  = 4'd9;
  localparam logic [7:0] HOUR_MAX = 8'd23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } set_state_t;

  typedef struct packed {
    logic [3:0] hrm;
    logic [3:0] hrl;
    logic [3:0] minm;
    logic [3:0] minl;
    logic [3:0] secm;
    logic [3:0] secl;
  } bcd_time_t;

  typedef struct packed {
    logic [3:0] hrm;
    logic [3:0] hrl;
    logic [3:0] minm;
    logic [3:0] minl;
  } bcd_alarm_t;

  function automatic logic [7:0] hour_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({4'd0, tens} * 8'd10) + {4'd0, ones};
  endfunction

  function automatic logic hhmm_valid(input logic [3:0] hrm, input logic [3:0] hrl,
                                      input logic [3:0] minm, input logic [3:0] minl);
    return (hrl <= HRL_MAX) && (hour_bin(hrm, hrl) <= HOUR_MAX) &&
           (minm <= MINM_MAX) && (minl <= MINL_MAX);
  endfunction

  function automatic logic time_valid(input bcd_time_t t);
    return hhmm_valid(t.hrm, t.hrl, t.minm, t.minl) &&
           (t.secm <= SECM_MAX) && (t.secl <= SECL_MAX);
  endfunction

  // 00 shows as 12, 13..23 fold down by twelve; minutes and seconds pass through.
  function automatic bcd_time_t to_12h(input bcd_time_t t);
    bcd_time_t  d;
    logic [7:0] h;
    d = t;
    h = hour_bin(t.hrm, t.hrl);
    if (h == 8'd0) begin
      h = 8'd12;
    end else if (h > 8'd12) begin
      h = h - 8'd12;
    end
    d.hrm = 4'd0;
    if (h >= 8'd10) begin
      h     = h - 8'd10;
      d.hrm = 4'd1;
    end
    d.hrl = h[3:0];
    return d;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to the time-base rate: tick is high for the
// single cycle in which the count sits at DIV-1; clr restarts the count at 0.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/rtc_timekeeper.sv
// BCD hh:mm:ss real-time clock with validated time load and 12/24-hour display.
// Define RTC_ALARM_EN to add the minute-resolution alarm ports and logic.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode12,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [23:0] set_time,
  output logic        set_err,
  output logic [3:0]  hrm,
  output logic [3:0]  hrl,
  output logic [3:0]  minm,
  output logic [3:0]  minl,
  output logic [3:0]  secm,
  output logic [3:0]  secl,
  output logic        pm,
  output logic        sec_tick
`ifdef RTC_ALARM_EN
  ,
  input  logic        alm_wr,
  input  logic [15:0] alm_time,
  input  logic        alm_on,
  input  logic        alm_ack,
  output logic        alarm_flag
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  set_state_t state;
  bcd_time_t  set_buf;
  bcd_time_t  cur_time;
  bcd_time_t  inc_time;
  bcd_time_t  next_time;
  bcd_time_t  disp;
  logic       tick;
  logic       commit;
  logic       tick_eff;

  assign commit   = (state == COMMIT);
  assign tick_eff = tick && !commit;

  rtc_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (commit),
    .tick (tick)
  );

  // Ripple-carry BCD increment of the stored 24-hour time.
  always_comb begin
    inc_time = cur_time;
    if (cur_time.secl != SECL_MAX) begin
      inc_time.secl = cur_time.secl + 4'd1;
    end else begin
      inc_time.secl = 4'd0;
      if (cur_time.secm != SECM_MAX) begin
        inc_time.secm = cur_time.secm + 4'd1;
      end else begin
        inc_time.secm = 4'd0;
        if (cur_time.minl != MINL_MAX) begin
          inc_time.minl = cur_time.minl + 4'd1;
        end else begin
          inc_time.minl = 4'd0;
          if (cur_time.minm != MINM_MAX) begin
            inc_time.minm = cur_time.minm + 4'd1;
          end else begin
            inc_time.minm = 4'd0;
            if (hour_bin(cur_time.hrm, cur_time.hrl) == HOUR_MAX) begin
              inc_time.hrm = 4'd0;
              inc_time.hrl = 4'd0;
            end else if (cur_time.hrl == HRL_MAX) begin
              inc_time.hrm = cur_time.hrm + 4'd1;
              inc_time.hrl = 4'd0;
            end else begin
              inc_time.hrl = cur_time.hrl + 4'd1;
            end
          end
        end
      end
    end
  end

  // A load in COMMIT takes priority over a coincident tick, which is dropped.
  always_comb begin
    next_time = cur_time;
    if (commit) begin
      next_time = set_buf;
    end else if (tick_eff) begin
      next_time = inc_time;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_time <= '0;
      disp     <= '0;
      pm       <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      cur_time <= next_time;
      disp     <= mode12 ? to_12h(next_time) : next_time;
      pm       <= (hour_bin(next_time.hrm, next_time.hrl) >= 8'd12);
      sec_tick <= tick_eff;
    end
  end

  assign hrm  = disp.hrm;
  assign hrl  = disp.hrl;
  assign minm = disp.minm;
  assign minl = disp.minl;
  assign secm = disp.secm;
  assign secl = disp.secl;

  // Load handshake: capture, validate, then commit with a prescaler restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      set_buf   <= '0;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
    end else begin
      set_err <= 1'b0;
      case (state)
        IDLE: begin
          if (set_valid && set_ready) begin
            set_buf   <= set_time;
            state     <= CHECK;
            set_ready <= 1'b0;
          end
        end
        CHECK: begin
          if (time_valid(set_buf)) begin
            state <= COMMIT;
          end else begin
            state     <= IDLE;
            set_ready <= 1'b1;
            set_err   <= 1'b1;
          end
        end
        COMMIT: begin
          state     <= IDLE;
          set_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          set_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef RTC_ALARM_EN
  bcd_alarm_t alm_reg;
  logic       alm_match;

  // Only a counted tick landing on hh:mm:00 can match; loads never do.
  assign alm_match = alm_on && tick_eff &&
                     (inc_time.secm == 4'd0) && (inc_time.secl == 4'd0) &&
                     (inc_time.hrm == alm_reg.hrm) && (inc_time.hrl == alm_reg.hrl) &&
                     (inc_time.minm == alm_reg.minm) && (inc_time.minl == alm_reg.minl);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alm_reg    <= '0;
      alarm_flag <= 1'b0;
    end else begin
      if (alm_wr && hhmm_valid(alm_time[15:12], alm_time[11:8], alm_time[7:4], alm_time[3:0])) begin
        alm_reg <= alm_time;
      end
      if (alm_match) begin
        alarm_flag <= 1'b1;
      end else if (alm_ack) begin
        alarm_flag <= 1'b0;
      end
    end
  end
`endif

endmodule
